// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, default frame size and {CPOL,CPHA} mode codes.
// Used by spi_slave and spi_master.
package spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } spi_state_e;

   localparam int SPI_FRAME_SIZE = 8;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with rise/fall pulses from the last two samples.
// Pin-to-pulse latency SYNC_STAGES+1 CLK; no backpressure.
module spi_sync_edge
   import spi_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign dout = sync_q[SYNC_STAGES-1];
   assign rise = dout & ~prev_q;
   assign fall = ~dout & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder, all CPOL/CPHA modes, MSB first; pins oversampled, events land SYNC_STAGES+1 CLK after the pin.
// Tx is a one-entry valid/ready buffer (ready while empty); Rx is a one-CLK valid pulse with no backpressure.
module spi_slave
   import spi_pkg::*;
#(
   parameter int FRAME_SIZE  = SPI_FRAME_SIZE,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  CLK,
   input  logic                  RST_,
   input  logic                  CPOL,
   input  logic                  CPHA,
   input  logic                  SCK,
   input  logic                  CS_n,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  MISO_OE,
   input  logic [FRAME_SIZE-1:0] Tx_DATA,
   input  logic                  Tx_Valid,
   output logic                  Tx_Ready,
   output logic [FRAME_SIZE-1:0] Rx_DATA,
   output logic                  Rx_Valid,
   output logic                  Tx_Underrun,
   output logic                  Frame_Err
);

   localparam int              CNT_W    = $clog2(FRAME_SIZE);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_SIZE - 1);

   spi_state_e            state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [FRAME_SIZE-1:0] rx_sh_q, rx_sh_d;
   logic [FRAME_SIZE-1:0] rx_data_q, rx_data_d;
   logic [FRAME_SIZE-1:0] tx_q, tx_d;
   logic [FRAME_SIZE-1:0] buf_q, buf_d;
   logic                  buf_vld_q, buf_vld_d;
   logic                  miso_q, miso_d;
   logic                  oe_q, oe_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  underrun_q, underrun_d;
   logic                  frame_err_q, frame_err_d;
   logic                  ur_pend_q, ur_pend_d;

   logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
   logic sck_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;
   logic lead_ev, trail_ev, sample_ev, shift_ev, hs;
   logic load, end_reload, tx_upd;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
      .clk(CLK), .rst(RST_), .din(SCK),
      .dout(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
      .clk(CLK), .rst(RST_), .din(CS_n),
      .dout(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
      .clk(CLK), .rst(RST_), .din(MOSI),
      .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   assign lead_ev   = (mode_q == MODE0 || mode_q == MODE1) ? sck_rise : sck_fall;
   assign trail_ev  = (mode_q == MODE0 || mode_q == MODE1) ? sck_fall : sck_rise;
   assign sample_ev = mode_q[0] ? trail_ev : lead_ev;
   assign shift_ev  = mode_q[0] ? lead_ev  : trail_ev;
   assign hs        = Tx_Valid & ~buf_vld_q;

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      bit_cnt_d   = bit_cnt_q;
      rx_sh_d     = rx_sh_q;
      rx_data_d   = rx_data_q;
      tx_d        = tx_q;
      buf_d       = buf_q;
      buf_vld_d   = buf_vld_q;
      miso_d      = miso_q;
      oe_d        = oe_q;
      rx_valid_d  = 1'b0;
      underrun_d  = 1'b0;
      frame_err_d = 1'b0;
      ur_pend_d   = ur_pend_q;
      load        = 1'b0;
      end_reload  = 1'b0;
      tx_upd      = 1'b0;

      if (state_q == IDLE) begin
         if (cs_fall) begin
            state_d   = ACTIVE;
            mode_d    = {CPOL, CPHA};
            oe_d      = 1'b1;
            bit_cnt_d = '0;
            ur_pend_d = 1'b0;
            load      = ~CPHA;
         end
      end else if (cs_rise) begin
         state_d   = IDLE;
         oe_d      = 1'b0;
         bit_cnt_d = '0;
         ur_pend_d = 1'b0;
         if (bit_cnt_q != '0) frame_err_d = 1'b1;
      end else begin
         if (sample_ev) begin
            rx_sh_d = {rx_sh_q[FRAME_SIZE-2:0], mosi_s};
            // An end-of-frame reload that found the buffer empty is reported once the next frame really begins.
            if (bit_cnt_q == '0 && ur_pend_q) begin
               underrun_d = 1'b1;
               ur_pend_d  = 1'b0;
            end
            if (bit_cnt_q == LAST_BIT) begin
               rx_data_d  = rx_sh_d;
               rx_valid_d = 1'b1;
               bit_cnt_d  = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         if (shift_ev) begin
            if (bit_cnt_q == '0) begin
               load       = 1'b1;
               end_reload = ~mode_q[0];
            end else begin
               tx_d   = {tx_q[FRAME_SIZE-2:0], 1'b0};
               tx_upd = 1'b1;
            end
         end
      end

      if (load) begin
         tx_upd = 1'b1;
         if (hs) begin
            tx_d = Tx_DATA;
         end else if (buf_vld_q) begin
            tx_d      = buf_q;
            buf_vld_d = 1'b0;
         end else begin
            tx_d = '0;
            if (end_reload) ur_pend_d = 1'b1;
            else            underrun_d = 1'b1;
         end
      end else if (hs) begin
         buf_d     = Tx_DATA;
         buf_vld_d = 1'b1;
      end

      if (tx_upd) miso_d = tx_d[FRAME_SIZE-1];
   end

   always_ff @(posedge CLK) begin
      if (RST_) begin
         state_q     <= IDLE;
         mode_q      <= MODE0;
         bit_cnt_q   <= '0;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         tx_q        <= '0;
         buf_q       <= '0;
         buf_vld_q   <= 1'b0;
         miso_q      <= 1'b0;
         oe_q        <= 1'b0;
         rx_valid_q  <= 1'b0;
         underrun_q  <= 1'b0;
         frame_err_q <= 1'b0;
         ur_pend_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         tx_q        <= tx_d;
         buf_q       <= buf_d;
         buf_vld_q   <= buf_vld_d;
         miso_q      <= miso_d;
         oe_q        <= oe_d;
         rx_valid_q  <= rx_valid_d;
         underrun_q  <= underrun_d;
         frame_err_q <= frame_err_d;
         ur_pend_q   <= ur_pend_d;
      end
   end

   assign MISO        = miso_q;
   assign MISO_OE     = oe_q;
   assign Tx_Ready    = ~buf_vld_q;
   assign Rx_DATA     = rx_data_q;
   assign Rx_Valid    = rx_valid_q;
   assign Tx_Underrun = underrun_q;
   assign Frame_Err   = frame_err_q;

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI responder for the peer end of the team's SPI master; one 8-bit full-duplex frame per byte, MSB first, all four CPOL/CPHA modes. SCK, CS_n and MOSI are asynchronous and are oversampled in the CLK domain. Bytes are exchanged with local logic through a Tx valid/ready handshake and an Rx valid pulse.

Parameters:
FRAME_SIZE, 8, bits per frame (MSB first); bit counter width is clog2(FRAME_SIZE).
SYNC_STAGES, 2, flip-flop stages on SCK, CS_n and MOSI (minimum 2).

Ports:
CLK  input  1  system clock; sole clock domain.
RST_  input  1  reset, synchronous, active-high.
CPOL  input  1  SCK idle level; sampled only in IDLE.
CPHA  input  1  0 = sample on leading edge, 1 = sample on trailing edge; sampled only in IDLE.
SCK  input  1  serial clock from master (asynchronous).
CS_n  input  1  chip select, active-low (asynchronous).
MOSI  input  1  serial data in (asynchronous).
MISO  output  1  serial data out.
MISO_OE  output  1  MISO drive enable; high only while selected.
Tx_DATA  input  FRAME_SIZE  next byte to transmit.
Tx_Valid  input  1  Tx_DATA valid.
Tx_Ready  output  1  holding buffer empty; transfer occurs when Tx_Valid & Tx_Ready.
Rx_DATA  output  FRAME_SIZE  last received byte; held until the next completed frame.
Rx_Valid  output  1  one-CLK pulse when Rx_DATA updates.
Tx_Underrun  output  1  one-CLK pulse when a frame starts with an empty buffer.
Frame_Err  output  1  one-CLK pulse when CS_n deasserts mid-frame.

Behaviour:
- Reset: MISO=0, MISO_OE=0, Tx_Ready=1, Rx_DATA=0, Rx_Valid=0, Tx_Underrun=0, Frame_Err=0, buffer empty, bit count 0, state IDLE. Reset mid-frame abandons the frame without any pulse.
- Inputs pass through SYNC_STAGES flops. Edge detection compares the last two synchronised samples. Latency from pin edge to internal event is SYNC_STAGES+1 CLK. SCK high and low times must each be at least SYNC_STAGES+2 CLK.
- Leading edge is rising when CPOL=0 and falling when CPOL=1. The sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1. The shift edge is the other edge.
- States:
  - IDLE: wait for synchronised CS_n to fall, then latch CPOL/CPHA and go to ACTIVE. If CPHA=0, load the shift register now.
  - ACTIVE: on each sample edge, shift synchronised MOSI into the rx shift register LSB and increment the bit count. On each shift edge, shift the tx register left and drive MISO from its MSB, with these exceptions:
    - CPHA=1: the first leading edge of a frame loads the tx register instead of shifting.
    - CPHA=0: the shift edge after the FRAME_SIZE-th sample reloads the tx register for the next frame.
  - Frame completion: at the FRAME_SIZE-th sample, Rx_DATA is assigned the assembled byte and Rx_Valid pulses in the same cycle. The bit count wraps to 0 and the state stays ACTIVE while CS_n is low (back-to-back frames).
  - CS_n rising: return to IDLE and set MISO_OE=0. If bit count != 0, pulse Frame_Err, discard the partial byte and leave Rx_DATA unchanged.
- Tx load rules:
  - A load consumes the buffer and sets Tx_Ready=1.
  - If the buffer is empty at load, 0x00 is sent and Tx_Underrun pulses.
  - A handshake in the same cycle as a load bypasses into the tx register; no underrun and no pulse.
  - Tx_Ready falls the cycle after a handshake.
- MISO is driven from tx register MSB, MISO_OE=1 from the CS assertion cycle until CS deassertion. MISO holds its last value when not driven.
- SCK edges while CS_n is high are ignored. CPOL/CPHA changes during ACTIVE are ignored.

Decomposition:
- Package spi_pkg: state encoding (IDLE, ACTIVE), the FRAME_SIZE default, and the mode constants MODE0..MODE3 as {CPOL,CPHA}; the existing spi_master shares it.
- One sub-module, spi_sync_edge: a SYNC_STAGES synchroniser plus rise/fall pulse outputs, instantiated for SCK and CS_n. MOSI uses the synchroniser only.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0): preload Tx 0x3C, master sends 0xA5 with SCK half-period 6 CLK -> MISO bits 0,0,1,1,1,1,0,0; Rx_DATA=0xA5 with a single Rx_Valid pulse.
- Mode 3 (CPOL=1, CPHA=1): preload 0xC3, master sends 0x5A -> MISO shows 0xC3; Rx_DATA=0x5A; MISO_OE low after CS_n rises.
- Back-to-back in mode 0: Tx 0x11 then 0x22 queued via handshake, master sends 0xF0,0x0F with CS_n held low -> two Rx_Valid pulses (0xF0, 0x0F); MISO 0x11 then 0x22; no Tx_Underrun.
- Underrun: no Tx_Valid before CS_n falls -> MISO all zero, one Tx_Underrun pulse, Rx still correct.
- Abort: CS_n rises after 5 SCK cycles -> Frame_Err pulses once, no Rx_Valid, Rx_DATA keeps its previous value; the next full frame is received correctly.
- Reset mid-frame: RST_=1 after bit 3 -> all outputs at reset values the next cycle, no pulses; a subsequent frame is received correctly.
